// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron datapath blocks.
package neuron_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StFin, StOut} state_e;

  // Widest value and result the saturate helper handles.
  localparam int unsigned MaxAccW = 128;
  localparam int unsigned MaxBits = 64;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = unsigned'(i + 1);
    end
    return result;
  endfunction

  // Clip a signed value to a signed bits-wide word. Returns {sat, y}; y is
  // sign-extended into MaxBits, so callers keep only the low bits they need.
  function automatic logic [MaxBits:0] saturate(input logic signed [MaxAccW-1:0] value,
                                                input int unsigned bits);
    logic signed [MaxAccW-1:0] hi;
    logic signed [MaxAccW-1:0] lo;
    hi = (MaxAccW'(1) << (bits - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) return {1'b1, hi[MaxBits-1:0]};
    if (value < lo) return {1'b1, lo[MaxBits-1:0]};
    return {1'b0, value[MaxBits-1:0]};
  endfunction

endpackage

// File: rtl/neuron_mac_lanes.sv
// Combinational bank of LANES signed multipliers whose products are summed.
module neuron_mac_lanes
  import neuron_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned BITS  = 16,
  localparam int unsigned SUMW = 2 * BITS + clog2(LANES)
) (
  input  logic [LANES*BITS-1:0] xv,
  input  logic [LANES*BITS-1:0] wv,
  output logic signed [SUMW-1:0] sum
);

  logic signed [2*BITS-1:0] prod;

  always_comb begin
    prod = '0;
    sum  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      prod = (2 * BITS)'($signed(xv[i*BITS +: BITS])) * (2 * BITS)'($signed(wv[i*BITS +: BITS]));
      sum  = sum + SUMW'(prod);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Fixed-point linear neuron: y = sat(sum(x[i]*w[i]) + b) with optional ReLU,
// time-multiplexing LANES multipliers over N inputs.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned BITS  = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned LANES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*BITS-1:0] x,
  input  logic [N*BITS-1:0] w,
  input  logic [BITS-1:0] b,
  input  logic            relu_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] y,
  output logic            sat
);

  localparam int unsigned BEATS = (N + LANES - 1) / LANES;
  localparam int unsigned ACCW  = 2 * BITS + clog2(N + 1) + 1;
  localparam int unsigned SUMW  = 2 * BITS + clog2(LANES);
  localparam int unsigned BEATW = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int unsigned LANEW = LANES * BITS;

  state_e                  state_q, state_d;
  logic [N*BITS-1:0]       x_q, w_q;
  logic                    relu_q;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [BEATW-1:0]        beat_q, beat_d;
  logic [BITS-1:0]         y_q, y_d;
  logic                    sat_q, sat_d;
  logic [BEATS-1:0][LANEW-1:0] x_pad, w_pad;
  logic signed [SUMW-1:0]  lane_sum;
  logic signed [ACCW-1:0]  r;
  logic [MaxBits:0]        clip;
  logic                    accept;
  logic                    unused_clip;

  // Zero padding makes indices >= N contribute nothing on the last beat.
  assign x_pad = (BEATS * LANEW)'(x_q);
  assign w_pad = (BEATS * LANEW)'(w_q);

  neuron_mac_lanes #(
    .LANES(LANES),
    .BITS (BITS)
  ) u_lanes (
    .xv (x_pad[beat_q]),
    .wv (w_pad[beat_q]),
    .sum(lane_sum)
  );

  assign accept      = (state_q == StIdle) && in_valid;
  assign in_ready    = (state_q == StIdle) && !rst;
  assign out_valid   = (state_q == StOut);
  assign y           = y_q;
  assign sat         = sat_q;
  assign r           = acc_q >>> FRAC;
  assign clip        = saturate(MaxAccW'(r), BITS);
  assign unused_clip = ^clip[MaxBits-1:BITS];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    y_d     = y_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d   = ACCW'($signed(b)) <<< FRAC;
          beat_d  = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d  = acc_q + ACCW'(lane_sum);
        beat_d = beat_q + BEATW'(1);
        if (beat_q == BEATW'(BEATS - 1)) state_d = StFin;
      end
      StFin: begin
        y_d   = clip[BITS-1:0];
        sat_d = clip[MaxBits];
        if (relu_q && y_d[BITS-1]) y_d = '0;
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      beat_q  <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      x_q     <= '0;
      w_q     <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      if (accept) begin
        x_q    <= x;
        w_q    <= w;
        relu_q <= relu_en;
      end
    end
  end

endmodule
